mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage LC-3b pipeline, between the EX/MEM and MEM/WB pipeline registers.
- Executes data-memory transactions against a handshaked data memory: LDW, LDB, STW, STB, LDI, STI and TRAP vector fetch.
- Produces the effective-address value (mem_marmux_out) and the loaded or stored data value (mem_mdrmux_out) that MEM/WB captures.
- Asserts mem_stall while a transaction is outstanding, so upstream stages and the MEM/WB load enable hold.

Parameters:
- none (all datapath widths fixed at 16 bits by lc3b_types)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
ex_mem_valid  input  1  EX/MEM holds a live instruction (0 = bubble)
ex_mem_opcode_out  input  4  opcode of instruction in MEM
ex_mem_alu_out  input  16  effective address (or ALU result for non-memory ops)
ex_mem_sr_out  input  16  store source register value
advance  input  1  MEM/WB load enable this cycle (global pipeline advance)
dmem_resp  input  1  data memory completes current access this cycle
dmem_rdata  input  16  read data, valid when dmem_resp=1
dmem_address  output  16  memory address, bit 0 always 0
dmem_read  output  1  read strobe
dmem_write  output  1  write strobe
dmem_byte_enable  output  2  byte lanes {hi,lo}
dmem_wdata  output  16  write data
mem_marmux_out  output  16  address of final access / pass-through ALU value
mem_mdrmux_out  output  16  load result or store data
mem_stall  output  1  memory op in MEM not yet complete

Behaviour:
- Memory op: ex_mem_valid=1 and opcode in {LDB 0010, STB 0011, LDW 0110, STW 0111, LDI 1010, STI 1011, TRAP 1111}. All other opcodes and bubbles are non-memory ops.
- FSM states: IDLE, ACC1, ACC2, DONE.
  - IDLE:
    - Memory op present: latch opcode, ex_mem_alu_out and ex_mem_sr_out into the issue registers, go to ACC1.
    - Otherwise stay in IDLE.
  - ACC1: drive the first access.
    - Strobes held constant until dmem_resp.
    - On resp for LDI/STI: latch dmem_rdata into ptr register, go to ACC2.
    - On resp for all other memory ops: latch the result, go to DONE.
  - ACC2: LDI reads at ptr; STI writes at ptr. On resp, go to DONE.
  - DONE: hold results.
    - advance=1: go to IDLE.
    - advance=0: stay in DONE. No re-issue of the access.
- mem_stall = memory op present and state != DONE. Combinational. In IDLE it is already 1 in the same cycle a memory op arrives.
- First-access strobes by opcode:
  - Loads, LDI and STI: read.
  - STB and STW: write.
- Byte lanes:
  - Word access: byte_enable=2'b11.
  - Byte access: 2'b01 if addr[0]=0, 2'b10 if addr[0]=1.
  - dmem_address = {addr[15:1],1'b0}.
  - STB: wdata = {sr[7:0],sr[7:0]}. STW and STI: wdata = sr.
- Results:
  - LDB: mdr = sign-extended selected byte.
  - LDW, LDI and TRAP: mdr = word read.
  - Stores: mdr = store data.
  - mar = address of the final access. For LDI/STI this is ptr.
- Non-memory op: mar = ex_mem_alu_out, mdr = 16'h0000, combinational pass-through, no stall.
- Strobes are 0 in IDLE and DONE. read and write are never both 1.
- ex_mem inputs are ignored after issue. Upstream holds them while mem_stall=1, but the issue registers are authoritative.
- dmem_resp outside ACC1/ACC2 is ignored.
- Reset (asynchronous, any state, including mid-access):
  - State goes to IDLE.
  - Strobes, byte_enable, address, wdata, mar, mdr, ptr and issue registers all go to 0.
  - mem_stall = 0 while reset_n=0.
- Latency:
  - Single access: (cycles to first resp) + 1 to DONE.
  - Indirect: two handshakes + 1.
  - Zero-wait memory (resp in the first ACC cycle): LDW stalls exactly 2 cycles, LDI exactly 3.

Decomposition:
- Opcode constants (op_ldb, op_stb, op_ldw, op_stw, op_ldi, op_sti, op_trap) go in lc3b_types.
- Add an enum lc3b_mem_state {IDLE, ACC1, ACC2, DONE} to lc3b_types.
- One sub-module, mem_byte_align: combinational lane/enable generation and LDB sign-extension, shared with the future cache byte path.

Test Plan:
- Reset mid-ACC1 of an LDW: reset_n low with resp pending → state IDLE, dmem_read=0, mem_stall=0, outputs 16'h0000.
- LDW at 16'h3001, rdata 16'hBEEF after a 3-cycle wait:
  - dmem_address=16'h3000, byte_enable=2'b11, read held for 3 cycles.
  - mdr=16'hBEEF, mar=16'h3000.
  - mem_stall deasserts in DONE.
- LDB at 16'h4001, rdata 16'h8A12 → mdr=16'hFF8A, byte_enable=2'b10. LDB at 16'h4000 with the same rdata → mdr=16'h0012.
- STB at 16'h5001, sr=16'h00C3 → dmem_write=1, wdata=16'hC3C3, byte_enable=2'b10.
- LDI at 16'h6000, first rdata 16'h7000, second rdata 16'h1234, zero-wait memory:
  - Reads at 16'h6000 then 16'h7000.
  - mar=16'h7000, mdr=16'h1234, 3 stall cycles.
- STI completes with advance=0 for 4 cycles → block stays in DONE, no second write, mem_stall=0. Then advance=1 → IDLE. ADD opcode following → mar=alu_out, no stall.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types: LC-3b opcode constants and MEM-stage state encoding
package lc3b_types;
  localparam logic [3:0] op_ldb  = 4'b0010;
  localparam logic [3:0] op_stb  = 4'b0011;
  localparam logic [3:0] op_ldw  = 4'b0110;
  localparam logic [3:0] op_stw  = 4'b0111;
  localparam logic [3:0] op_ldi  = 4'b1010;
  localparam logic [3:0] op_sti  = 4'b1011;
  localparam logic [3:0] op_trap = 4'b1111;
  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} lc3b_mem_state;
  function automatic logic is_mem_op(input logic [3:0] op);
    return op inside {op_ldb, op_stb, op_ldw, op_stw, op_ldi, op_sti, op_trap};
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: handshaked data-memory port between the MEM stage and data memory
interface mem_stage_if;
  logic [15:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_wdata;
  logic        dmem_resp;
  logic [15:0] dmem_rdata;
  modport master (output dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
                  input dmem_resp, dmem_rdata);
  modport slave  (input dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
                  output dmem_resp, dmem_rdata);
endinterface

// File: rtl/mem_byte_align.sv
// mem_byte_align: byte-lane enables, store byte replication and LDB sign extension
module mem_byte_align (
  input  logic        byte_i,
  input  logic        addr0_i,
  input  logic [15:0] sr_i,
  input  logic [15:0] rdata_i,
  output logic [1:0]  be_o,
  output logic [15:0] wdata_o,
  output logic [15:0] ldb_o
);
  logic [7:0] lane;
  always_comb begin
    be_o    = byte_i ? (addr0_i ? 2'b10 : 2'b01) : 2'b11;
    wdata_o = byte_i ? {2{sr_i[7:0]}} : sr_i;
    lane    = addr0_i ? rdata_i[15:8] : rdata_i[7:0];
    ldb_o   = {{8{lane[7]}}, lane};
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: LC-3b MEM stage sequencing direct and indirect data-memory accesses
module mem_stage
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_mem_valid,
  input  logic [3:0]  ex_mem_opcode_out,
  input  logic [15:0] ex_mem_alu_out,
  input  logic [15:0] ex_mem_sr_out,
  input  logic        advance,
  mem_stage_if.master dmem,
  output logic [15:0] mem_marmux_out,
  output logic [15:0] mem_mdrmux_out,
  output logic        mem_stall
);
  lc3b_mem_state state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d, sr_q, sr_d, ptr_q, ptr_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [15:0] acc_addr, wdata_al, ldb_val;
  logic [1:0]  be;
  logic        mem_op, byte_op, store_op, ind_op, acc1, acc2, rd, wr, pass;
  assign mem_op   = ex_mem_valid && is_mem_op(ex_mem_opcode_out);
  assign byte_op  = op_q == op_ldb || op_q == op_stb;
  assign store_op = op_q == op_stb || op_q == op_stw;
  assign ind_op   = op_q == op_ldi || op_q == op_sti;
  assign acc1     = state_q == ACC1;
  assign acc2     = state_q == ACC2;
  assign acc_addr = acc1 ? {addr_q[15:1], 1'b0} : acc2 ? {ptr_q[15:1], 1'b0} : '0;
  assign rd       = (acc1 && !store_op) || (acc2 && op_q == op_ldi);
  assign wr       = (acc1 && store_op) || (acc2 && op_q == op_sti);
  assign pass     = state_q == IDLE && !mem_op;
  mem_byte_align u_align (
    .byte_i (byte_op),
    .addr0_i(addr_q[0]),
    .sr_i   (sr_q),
    .rdata_i(dmem.dmem_rdata),
    .be_o   (be),
    .wdata_o(wdata_al),
    .ldb_o  (ldb_val)
  );
  assign dmem.dmem_address     = acc_addr;
  assign dmem.dmem_read        = rd;
  assign dmem.dmem_write       = wr;
  assign dmem.dmem_byte_enable = (acc1 || acc2) ? be : '0;
  assign dmem.dmem_wdata       = wr ? wdata_al : '0;
  assign mem_stall      = reset_n && mem_op && state_q != DONE;
  assign mem_marmux_out = !reset_n ? '0 : pass ? ex_mem_alu_out : mar_q;
  assign mem_mdrmux_out = pass ? '0 : mdr_q;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    sr_d    = sr_q;
    ptr_d   = ptr_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    case (state_q)
      IDLE: if (mem_op) begin
        state_d = ACC1;
        op_d    = ex_mem_opcode_out;
        addr_d  = ex_mem_alu_out;
        sr_d    = ex_mem_sr_out;
      end
      ACC1: if (dmem.dmem_resp) begin
        if (ind_op) begin
          state_d = ACC2;
          ptr_d   = dmem.dmem_rdata;
        end else begin
          state_d = DONE;
          mar_d   = acc_addr;
          mdr_d   = op_q == op_ldb ? ldb_val : store_op ? wdata_al : dmem.dmem_rdata;
        end
      end
      ACC2: if (dmem.dmem_resp) begin
        state_d = DONE;
        mar_d   = ptr_q;
        mdr_d   = op_q == op_ldi ? dmem.dmem_rdata : sr_q;
      end
      DONE: if (advance) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      sr_q    <= '0;
      ptr_q   <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      sr_q    <= sr_d;
      ptr_q   <= ptr_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized transaction-level check of mem_stage against a word-memory model
module tb_mem_stage;
  localparam logic [3:0] k_ldb = 4'b0010, k_stb = 4'b0011, k_ldw = 4'b0110, k_stw = 4'b0111;
  localparam logic [3:0] k_ldi = 4'b1010, k_sti = 4'b1011, k_trap = 4'b1111, k_add = 4'b0001;
  logic        clk, reset_n, ex_mem_valid, advance, mem_stall;
  logic [3:0]  ex_mem_opcode_out;
  logic [15:0] ex_mem_alu_out, ex_mem_sr_out, mem_marmux_out, mem_mdrmux_out;
  mem_stage_if dmem();
  mem_stage dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ex_mem_valid     (ex_mem_valid),
    .ex_mem_opcode_out(ex_mem_opcode_out),
    .ex_mem_alu_out   (ex_mem_alu_out),
    .ex_mem_sr_out    (ex_mem_sr_out),
    .advance          (advance),
    .dmem             (dmem),
    .mem_marmux_out   (mem_marmux_out),
    .mem_mdrmux_out   (mem_mdrmux_out),
    .mem_stall        (mem_stall)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [15:0] mem [32768];
  int n_chk = 0, n_fail = 0, stall_total = 0, stall_base = 0;
  logic        chk = 1'b0, chk_res = 1'b0, exp_read = 1'b0, exp_write = 1'b0, exp_stall = 1'b0;
  logic [15:0] exp_addr = '0, exp_wdata = '0, exp_mar = '0, exp_mdr = '0;
  logic [1:0]  exp_be = '0, cap_be = '0;
  logic [15:0] cap_mar = '0, cap_mdr = '0, cap_wdata = '0, last_mar = '0, last_mdr = '0;
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic memop(input logic [3:0] o);
    return o inside {k_ldb, k_stb, k_ldw, k_stw, k_ldi, k_sti, k_trap};
  endfunction
  // Per-cycle comparison against the expectations the transaction model posted for this cycle
  always @(negedge clk) if (chk) begin
    if (mem_stall) stall_total++;
    check("read", 16'(dmem.dmem_read), 16'(exp_read));
    check("write", 16'(dmem.dmem_write), 16'(exp_write));
    check("stall", 16'(mem_stall), 16'(exp_stall));
    if (exp_read || exp_write) begin
      check("address", dmem.dmem_address, exp_addr);
      check("byte_enable", 16'(dmem.dmem_byte_enable), 16'(exp_be));
    end
    if (exp_write) check("wdata", dmem.dmem_wdata, exp_wdata);
    if (chk_res) begin
      check("mar", mem_marmux_out, exp_mar);
      check("mdr", mem_mdrmux_out, exp_mdr);
      cap_mar = mem_marmux_out;
      cap_mdr = mem_mdrmux_out;
    end
    if (dmem.dmem_read || dmem.dmem_write) begin
      cap_be    = dmem.dmem_byte_enable;
      cap_wdata = dmem.dmem_wdata;
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_exp(input logic r, w, input logic [15:0] a, input logic [1:0] be,
                         input logic [15:0] wd, input logic st, res, input logic [15:0] mar, mdr);
    exp_read = r; exp_write = w; exp_addr = a; exp_be = be; exp_wdata = wd;
    exp_stall = st; chk_res = res; exp_mar = mar; exp_mdr = mdr;
  endtask
  task automatic spurious();
    dmem.dmem_resp  = 1'($urandom);
    dmem.dmem_rdata = 16'($urandom);
  endtask
  task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
    mem[a[15:1]] = d;
  endtask
  task automatic access(input logic r, w, input logic [15:0] a, input logic [1:0] be,
                        input logic [15:0] wd, input int wt);
    for (int i = 0; i <= wt; i++) begin
      cyc();
      dmem.dmem_resp  = (i == wt);
      dmem.dmem_rdata = (i == wt) ? mem[a[15:1]] : 16'($urandom);
      ex_mem_alu_out  = 16'($urandom);
      ex_mem_sr_out   = 16'($urandom);
      set_exp(r, w, a, be, wd, 1'b1, 1'b0, '0, '0);
    end
  endtask
  task automatic run_op(input logic [3:0] op, input logic [15:0] alu, sr, input int w1, w2, adv);
    logic st, byt, ind;
    logic [15:0] a0, ptr, fmar, fmdr, word;
    logic [7:0] lane;
    logic [1:0] be0;
    st  = op == k_stb || op == k_stw;
    byt = op == k_ldb || op == k_stb;
    ind = op == k_ldi || op == k_sti;
    a0  = {alu[15:1], 1'b0};
    be0 = byt ? (alu[0] ? 2'b10 : 2'b01) : 2'b11;
    cyc();
    ex_mem_valid = 1'b1; ex_mem_opcode_out = op; ex_mem_alu_out = alu; ex_mem_sr_out = sr;
    advance = 1'b0;
    spurious();
    stall_base = stall_total;
    set_exp(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0);
    access(!st, st, a0, be0, byt ? {2{sr[7:0]}} : sr, w1);
    word = mem[a0[15:1]];
    if (st) mem[a0[15:1]] = !byt ? sr : alu[0] ? {sr[7:0], word[7:0]} : {word[15:8], sr[7:0]};
    if (ind) begin
      ptr = word;
      access(op == k_ldi, op == k_sti, {ptr[15:1], 1'b0}, 2'b11, sr, w2);
      if (op == k_sti) mem[ptr[15:1]] = sr;
      fmar = ptr;
      fmdr = op == k_ldi ? mem[ptr[15:1]] : sr;
    end else begin
      lane = alu[0] ? word[15:8] : word[7:0];
      fmar = a0;
      fmdr = op == k_ldb ? {{8{lane[7]}}, lane} : op == k_stb ? {2{sr[7:0]}} : op == k_stw ? sr : word;
    end
    for (int d = 0; d <= adv; d++) begin
      cyc();
      advance = (d == adv);
      spurious();
      set_exp(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, fmar, fmdr);
    end
    last_mar = fmar;
    last_mdr = fmdr;
    @(negedge clk);
    #1;
  endtask
  task automatic idle_op(input logic v, input logic [3:0] op, input logic [15:0] alu);
    cyc();
    ex_mem_valid = v; ex_mem_opcode_out = op; ex_mem_alu_out = alu; ex_mem_sr_out = 16'($urandom);
    advance = 1'b1;
    spurious();
    set_exp(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, alu, '0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [3:0] mops [7];
    logic [3:0] op;
    logic v;
    mops = '{k_ldb, k_stb, k_ldw, k_stw, k_ldi, k_sti, k_trap};
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    reset_n = 1'b0; advance = 1'b0;
    ex_mem_valid = 1'b1; ex_mem_opcode_out = k_ldw; ex_mem_alu_out = 16'h1234; ex_mem_sr_out = 16'h5678;
    dmem.dmem_resp = 1'b0; dmem.dmem_rdata = '0;
    #2;
    check("rst_stall", 16'(mem_stall), 16'h0);
    check("rst_read", 16'(dmem.dmem_read), 16'h0);
    check("rst_write", 16'(dmem.dmem_write), 16'h0);
    check("rst_addr", dmem.dmem_address, 16'h0000);
    check("rst_be", 16'(dmem.dmem_byte_enable), 16'h0);
    check("rst_wdata", dmem.dmem_wdata, 16'h0000);
    check("rst_mar", mem_marmux_out, 16'h0000);
    check("rst_mdr", mem_mdrmux_out, 16'h0000);
    repeat (2) cyc();
    reset_n = 1'b1; ex_mem_valid = 1'b0; ex_mem_alu_out = 16'h0000;
    set_exp(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    chk = 1'b1;
    // Reset in the middle of the first access of an LDW while a response is pending
    wr_word(16'h3000, 16'hBEEF);
    cyc();
    ex_mem_valid = 1'b1; ex_mem_opcode_out = k_ldw; ex_mem_alu_out = 16'h3001; dmem.dmem_resp = 1'b0;
    set_exp(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0);
    cyc();
    set_exp(1'b1, 1'b0, 16'h3000, 2'b11, '0, 1'b1, 1'b0, '0, '0);
    @(negedge clk);
    #1;
    chk = 1'b0;
    dmem.dmem_resp = 1'b1; dmem.dmem_rdata = 16'hBEEF;
    #1 reset_n = 1'b0;
    #1;
    check("midrst_read", 16'(dmem.dmem_read), 16'h0);
    check("midrst_stall", 16'(mem_stall), 16'h0);
    check("midrst_addr", dmem.dmem_address, 16'h0000);
    check("midrst_mar", mem_marmux_out, 16'h0000);
    check("midrst_mdr", mem_mdrmux_out, 16'h0000);
    cyc();
    check("midrst_read_held", 16'(dmem.dmem_read), 16'h0);
    reset_n = 1'b1; dmem.dmem_resp = 1'b0; ex_mem_valid = 1'b0; ex_mem_alu_out = 16'h00A5;
    set_exp(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 16'h00A5, 16'h0000);
    chk = 1'b1;
    run_op(k_ldw, 16'h3001, 16'h0000, 2, 0, 0);
    check("ldw_mar", cap_mar, 16'h3000);
    check("ldw_mdr", cap_mdr, 16'hBEEF);
    check("model_ldw_mdr", last_mdr, 16'hBEEF);
    check("ldw_stall_cycles", 16'(stall_total - stall_base), 16'd4);
    wr_word(16'h4000, 16'h8A12);
    run_op(k_ldb, 16'h4001, 16'h0000, 1, 0, 0);
    check("ldb_hi_mdr", cap_mdr, 16'hFF8A);
    check("ldb_hi_be", 16'(cap_be), 16'h2);
    check("model_ldb_hi", last_mdr, 16'hFF8A);
    run_op(k_ldb, 16'h4000, 16'h0000, 0, 0, 1);
    check("ldb_lo_mdr", cap_mdr, 16'h0012);
    check("ldb_lo_be", 16'(cap_be), 16'h1);
    run_op(k_stb, 16'h5001, 16'h00C3, 1, 0, 0);
    check("stb_wdata", cap_wdata, 16'hC3C3);
    check("stb_be", 16'(cap_be), 16'h2);
    wr_word(16'h6000, 16'h7000);
    wr_word(16'h7000, 16'h1234);
    run_op(k_ldi, 16'h6000, 16'h0000, 0, 0, 0);
    check("ldi_mar", cap_mar, 16'h7000);
    check("ldi_mdr", cap_mdr, 16'h1234);
    check("model_ldi_mar", last_mar, 16'h7000);
    check("ldi_stall_cycles", 16'(stall_total - stall_base), 16'd3);
    run_op(k_ldw, 16'h2002, 16'h0000, 0, 0, 0);
    check("ldw0_stall_cycles", 16'(stall_total - stall_base), 16'd2);
    wr_word(16'h6100, 16'h6200);
    run_op(k_sti, 16'h6100, 16'hABCD, 1, 1, 4);
    check("sti_mar", cap_mar, 16'h6200);
    idle_op(1'b1, k_add, 16'h1357);
    @(negedge clk);
    #1;
    check("add_mar", mem_marmux_out, 16'h1357);
    check("add_stall", 16'(mem_stall), 16'h0);
    run_op(k_ldw, 16'h6200, 16'h0000, 0, 0, 0);
    check("sti_readback", cap_mdr, 16'hABCD);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        v = 1'($urandom);
        do op = 4'($urandom); while (v && memop(op));
        idle_op(v, op, 16'($urandom));
      end else begin
        run_op(mops[$urandom_range(0, 6)], 16'($urandom), 16'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end
    @(negedge clk);
    #1;
    chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
